// File: rtl/coin_pkg.sv
// Shared definitions for the coin acceptor: {i,j} coin codes and the classifier
// state encoding.
package coin_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_ONE  = 2'b10;
  localparam logic [1:0] COIN_TWO  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEAS = 2'd1,
    JAM  = 2'd2
  } coin_state_e;

  function automatic logic [1:0] coin_code(input logic big);
    return big ? COIN_TWO : COIN_ONE;
  endfunction

endpackage

// File: rtl/coin_acceptor_if.sv
// Signal bundle between the coin-slot world (sensors, machine busy) and the
// acceptor. Strobe i is a one-cycle valid with no ready: busy only gates presentation.
interface coin_acceptor_if #(
  parameter int FIFO_DEPTH = 4
);
  import coin_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          sense_a;
  logic          sense_b;
  logic          busy;
  logic          i;
  logic          j;
  logic          reject;
  logic          jam;
  logic [CW-1:0] fifo_count;
  coin_state_e   dbg_state;

  modport master (
    output sense_a, sense_b, busy,
    input  i, j, reject, jam, fifo_count, dbg_state
  );

  modport slave (
    input  sense_a, sense_b, busy,
    output i, j, reject, jam, fifo_count, dbg_state
  );

endinterface

// File: rtl/coin_acceptor_sensor_debounce.sv
// Two-flop synchroniser followed by a level debouncer: the output flips only after
// DEB_CYCLES consecutive synchronised samples disagree with it.
module sensor_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    // Any sample that agrees with the current level restarts the run count.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin-slot front end: debounces the sensors, classifies coins, queues them and
// presents each as a registered one-cycle {i,j} strobe when the machine is not busy.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int JAM_CYCLES = 1000,
  parameter int FIFO_DEPTH = 4
) (
  input logic            clk,
  input logic            reset,
  coin_acceptor_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int JW = $clog2(JAM_CYCLES + 1);

  logic da;
  logic db;

  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.sense_a),
    .level (da)
  );

  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.sense_b),
    .level (db)
  );

  coin_state_e     state_q, state_d;
  logic            big_q, big_d;
  logic [JW-1:0]   jam_cnt_q, jam_cnt_d;
  logic            push_req;
  logic            push_val;
  logic            jam_entry;

  always_comb begin
    state_d   = state_q;
    big_d     = big_q;
    jam_cnt_d = jam_cnt_q;
    push_req  = 1'b0;
    push_val  = 1'b0;
    jam_entry = 1'b0;
    case (state_q)
      IDLE: begin
        // db alone never starts a coin; only sensor A marks a passage.
        if (da) begin
          state_d   = MEAS;
          big_d     = 1'b0;
          jam_cnt_d = '0;
        end
      end
      MEAS: begin
        big_d     = big_q | db;
        jam_cnt_d = jam_cnt_q + JW'(1);
        if (!da) begin
          push_req = 1'b1;
          push_val = big_d;
          state_d  = IDLE;
        end else if (jam_cnt_q == JW'(JAM_CYCLES - 1)) begin
          state_d   = JAM;
          jam_entry = 1'b1;
        end
      end
      JAM: begin
        if (!da) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic [FIFO_DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]         wr_q, wr_d;
  logic [AW-1:0]         rd_q, rd_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  i_q, i_d;
  logic                  j_q, j_d;
  logic                  reject_q, reject_d;
  logic                  jam_q, jam_d;
  logic                  full;
  logic                  push_ok;
  logic                  pop;
  logic [1:0]            code;

  always_comb begin
    full    = (count_q == CW'(FIFO_DEPTH));
    push_ok = push_req && !full;
    // The i_q term forces an idle cycle so busy can catch up between strobes.
    pop     = (count_q != '0) && !bus.busy && !i_q;

    mem_d = mem_q;
    if (push_ok) mem_d[wr_q] = push_val;
    wr_d = push_ok ? wr_q + AW'(1) : wr_q;
    rd_d = pop ? rd_q + AW'(1) : rd_q;

    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    code     = pop ? coin_code(mem_q[rd_q]) : COIN_NONE;
    i_d      = code[1];
    j_d      = code[0];
    reject_d = (push_req && full) || jam_entry;
    jam_d    = (state_d == JAM);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      big_q     <= 1'b0;
      jam_cnt_q <= '0;
      mem_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      i_q       <= 1'b0;
      j_q       <= 1'b0;
      reject_q  <= 1'b0;
      jam_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      big_q     <= big_d;
      jam_cnt_q <= jam_cnt_d;
      mem_q     <= mem_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      count_q   <= count_d;
      i_q       <= i_d;
      j_q       <= j_d;
      reject_q  <= reject_d;
      jam_q     <= jam_d;
    end
  end

  assign bus.i          = i_q;
  assign bus.j          = j_q;
  assign bus.reject     = reject_q;
  assign bus.jam        = jam_q;
  assign bus.fifo_count = count_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: latency, classification, glitch rejection,
// back-pressure, overflow, jam and mid-coin reset.
module tb_coin_acceptor;
  import coin_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  coin_acceptor_if #(.FIFO_DEPTH(4)) bus ();

  coin_acceptor #(
    .DEB_CYCLES (4),
    .JAM_CYCLES (1000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  int reject_cnt = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Every strobe must match the next expected coin value.
  always @(negedge clk) begin
    if (bus.i === 1'b1) begin
      strobe_cnt++;
      if (exp_q.size() == 0) check("unexpected_strobe", 32'(1), 32'(0));
      else check("strobe_j", 32'(bus.j), 32'(exp_q.pop_front()));
    end
    if (bus.reject === 1'b1) reject_cnt++;
  end

  task automatic coin(input logic big, input bit expect_out);
    if (expect_out) exp_q.push_back(big);
    bus.sense_a = 1'b1;
    if (big) begin
      cyc(5);
      bus.sense_b = 1'b1;
      cyc(10);
      bus.sense_b = 1'b0;
      cyc(5);
    end else begin
      cyc(20);
    end
    bus.sense_a = 1'b0;
    cyc(12);
  endtask

  int s0;
  int r0;

  initial begin
    bus.sense_a = 1'b0;
    bus.sense_b = 1'b0;
    bus.busy    = 1'b0;
    reset       = 1'b0;
    cyc(3);
    check("rst_i", 32'(bus.i), 32'(0));
    check("rst_j", 32'(bus.j), 32'(0));
    check("rst_reject", 32'(bus.reject), 32'(0));
    check("rst_jam", 32'(bus.jam), 32'(0));
    check("rst_count", 32'(bus.fifo_count), 32'(0));
    check("rst_state", 32'(bus.dbg_state), 32'(IDLE));
    reset = 1'b1;
    cyc(2);

    // 1-unit coin with exact latency from the raw falling edge
    exp_q.push_back(1'b0);
    bus.sense_a = 1'b1;
    cyc(20);
    bus.sense_a = 1'b0;
    cyc(7);
    check("lat_i_early", 32'(bus.i), 32'(0));
    check("lat_count_queued", 32'(bus.fifo_count), 32'(1));
    cyc(1);
    check("lat_i", 32'(bus.i), 32'(1));
    check("lat_j", 32'(bus.j), 32'(0));
    check("lat_count_popped", 32'(bus.fifo_count), 32'(0));
    cyc(1);
    check("lat_i_single", 32'(bus.i), 32'(0));
    check("lat_strobes", 32'(strobe_cnt), 32'(1));
    cyc(10);

    // 2-unit coin
    s0 = strobe_cnt;
    coin(1'b1, 1'b1);
    check("big_strobes", 32'(strobe_cnt - s0), 32'(1));
    check("big_drained", 32'(exp_q.size()), 32'(0));

    // Glitches on both sensors
    s0 = strobe_cnt;
    bus.sense_a = 1'b1;
    cyc(3);
    bus.sense_a = 1'b0;
    cyc(15);
    bus.sense_b = 1'b1;
    cyc(3);
    bus.sense_b = 1'b0;
    cyc(15);
    check("glitch_strobes", 32'(strobe_cnt - s0), 32'(0));
    check("glitch_count", 32'(bus.fifo_count), 32'(0));
    check("glitch_state", 32'(bus.dbg_state), 32'(IDLE));

    // Back-pressure
    bus.busy = 1'b1;
    s0 = strobe_cnt;
    coin(1'b0, 1'b1);
    coin(1'b1, 1'b1);
    coin(1'b0, 1'b1);
    check("bp_count3", 32'(bus.fifo_count), 32'(3));
    check("bp_no_strobe", 32'(strobe_cnt - s0), 32'(0));
    bus.busy = 1'b0;
    cyc(1);
    check("bp_i1", 32'(bus.i), 32'(1));
    check("bp_j1", 32'(bus.j), 32'(0));
    check("bp_count2", 32'(bus.fifo_count), 32'(2));
    cyc(1);
    check("bp_gap", 32'(bus.i), 32'(0));
    bus.busy = 1'b1;
    cyc(3);
    check("bp_halt_i", 32'(bus.i), 32'(0));
    check("bp_halt_count", 32'(bus.fifo_count), 32'(2));
    bus.busy = 1'b0;
    cyc(1);
    check("bp_i2", 32'(bus.i), 32'(1));
    check("bp_j2", 32'(bus.j), 32'(1));
    check("bp_count1", 32'(bus.fifo_count), 32'(1));
    cyc(1);
    check("bp_gap2", 32'(bus.i), 32'(0));
    cyc(1);
    check("bp_i3", 32'(bus.i), 32'(1));
    check("bp_j3", 32'(bus.j), 32'(0));
    check("bp_count0", 32'(bus.fifo_count), 32'(0));
    cyc(3);

    // Overflow: fifth coin is dropped with one reject pulse
    bus.busy = 1'b1;
    r0 = reject_cnt;
    coin(1'b1, 1'b1);
    coin(1'b0, 1'b1);
    coin(1'b1, 1'b1);
    coin(1'b1, 1'b1);
    check("ovf_no_reject_yet", 32'(reject_cnt - r0), 32'(0));
    coin(1'b0, 1'b0);
    check("ovf_count", 32'(bus.fifo_count), 32'(4));
    check("ovf_reject", 32'(reject_cnt - r0), 32'(1));
    bus.busy = 1'b0;
    cyc(12);
    check("ovf_drain_count", 32'(bus.fifo_count), 32'(0));
    check("ovf_drain_exp", 32'(exp_q.size()), 32'(0));
    check("ovf_reject_after", 32'(reject_cnt - r0), 32'(1));

    // Jam
    s0 = strobe_cnt;
    r0 = reject_cnt;
    bus.sense_a = 1'b1;
    cyc(1100);
    check("jam_level", 32'(bus.jam), 32'(1));
    check("jam_state", 32'(bus.dbg_state), 32'(JAM));
    check("jam_reject", 32'(reject_cnt - r0), 32'(1));
    bus.sense_a = 1'b0;
    cyc(5);
    check("jam_held", 32'(bus.jam), 32'(1));
    cyc(3);
    check("jam_cleared", 32'(bus.jam), 32'(0));
    check("jam_idle", 32'(bus.dbg_state), 32'(IDLE));
    cyc(5);
    check("jam_no_strobe", 32'(strobe_cnt - s0), 32'(0));
    check("jam_count", 32'(bus.fifo_count), 32'(0));

    // Reset mid-MEAS with two coins queued
    bus.busy = 1'b1;
    coin(1'b1, 1'b0);
    coin(1'b0, 1'b0);
    check("rm_count2", 32'(bus.fifo_count), 32'(2));
    bus.sense_a = 1'b1;
    cyc(12);
    check("rm_meas", 32'(bus.dbg_state), 32'(MEAS));
    reset = 1'b0;
    bus.sense_a = 1'b0;
    cyc(1);
    check("rm_i", 32'(bus.i), 32'(0));
    check("rm_j", 32'(bus.j), 32'(0));
    check("rm_reject", 32'(bus.reject), 32'(0));
    check("rm_jam", 32'(bus.jam), 32'(0));
    check("rm_count", 32'(bus.fifo_count), 32'(0));
    check("rm_state", 32'(bus.dbg_state), 32'(IDLE));
    reset = 1'b1;
    bus.busy = 1'b0;
    s0 = strobe_cnt;
    cyc(20);
    check("rm_discarded", 32'(strobe_cnt - s0), 32'(0));
    coin(1'b1, 1'b1);
    check("rm_next_coin", 32'(strobe_cnt - s0), 32'(1));
    check("rm_next_exp", 32'(exp_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
